// File: rtl/bit_pattern_pkg.sv
// Shared constants and helpers for the serial bit-pattern detector family.
package bit_pattern_pkg;

    localparam logic [3:0] DEFAULT_PATTERN = 4'b1011;

    // Width needed to count 0..pat_w valid bits of history.
    function automatic int unsigned fill_w(input int unsigned pat_w);
        return int'($clog2(pat_w + 1));
    endfunction

endpackage

// File: rtl/bit_pattern_match.sv
// Combinational masked compare of a shift-register window against a pattern.
module bit_pattern_match #(
    parameter int unsigned W = 4
) (
    input  logic [W-1:0] window,
    input  logic [W-1:0] pattern,
    input  logic [W-1:0] mask,
    output logic         hit
);

    assign hit = ~|((window ^ pattern) & mask);

endmodule

// File: rtl/bit_pattern_param_detector.sv
// Serial sync/marker detector: masked runtime pattern, overlap select, saturating match count.
module bit_pattern_param_detector
    import bit_pattern_pkg::*;
#(
    parameter int unsigned      PAT_W         = 4,
    parameter int unsigned      CNT_W         = 8,
    parameter logic [PAT_W-1:0] RESET_PATTERN = PAT_W'(DEFAULT_PATTERN)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             data,
    input  logic             cfg_we,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic [PAT_W-1:0] cfg_mask,
    input  logic             cfg_overlap,
    output logic             detect,
    output logic [CNT_W-1:0] match_count,
    output logic             count_sat
);

    localparam int unsigned      FW       = fill_w(PAT_W);
    localparam logic [FW-1:0]    FILL_MAX = FW'(PAT_W);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    logic [PAT_W-1:0] shreg_q, shreg_d;
    logic [FW-1:0]    fill_q, fill_d;
    logic [PAT_W-1:0] pattern_q, pattern_d;
    logic [PAT_W-1:0] mask_q, mask_d;
    logic             overlap_q, overlap_d;
    logic             detect_q, detect_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             sat_q, sat_d;

    logic [PAT_W-1:0] nshreg;
    logic [FW-1:0]    nfill;
    logic             hit;
    logic             match;

    assign nshreg = {shreg_q[PAT_W-2:0], data};
    assign nfill  = (fill_q == FILL_MAX) ? fill_q : fill_q + FW'(1);

    bit_pattern_match #(
        .W(PAT_W)
    ) u_match (
        .window (nshreg),
        .pattern(pattern_q),
        .mask   (mask_q),
        .hit    (hit)
    );

    assign match = in_valid && (nfill == FILL_MAX) && hit;

    always_comb begin
        shreg_d   = shreg_q;
        fill_d    = fill_q;
        pattern_d = pattern_q;
        mask_d    = mask_q;
        overlap_d = overlap_q;
        detect_d  = 1'b0;
        count_d   = count_q;
        sat_d     = sat_q;

        // Reconfiguration wins over a same-edge data bit, which is dropped.
        if (cfg_we) begin
            pattern_d = cfg_pattern;
            mask_d    = cfg_mask;
            overlap_d = cfg_overlap;
            shreg_d   = '0;
            fill_d    = '0;
            count_d   = '0;
            sat_d     = 1'b0;
        end else if (in_valid) begin
            shreg_d = nshreg;
            fill_d  = (match && !overlap_q) ? '0 : nfill;
            if (match) begin
                detect_d = 1'b1;
                if (count_q != CNT_MAX) begin
                    count_d = count_q + CNT_W'(1);
                end
                if (count_d == CNT_MAX) begin
                    sat_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg_q   <= '0;
            fill_q    <= '0;
            pattern_q <= RESET_PATTERN;
            mask_q    <= '1;
            overlap_q <= 1'b1;
            detect_q  <= 1'b0;
            count_q   <= '0;
            sat_q     <= 1'b0;
        end else begin
            shreg_q   <= shreg_d;
            fill_q    <= fill_d;
            pattern_q <= pattern_d;
            mask_q    <= mask_d;
            overlap_q <= overlap_d;
            detect_q  <= detect_d;
            count_q   <= count_d;
            sat_q     <= sat_d;
        end
    end

    assign detect      = detect_q;
    assign match_count = count_q;
    assign count_sat   = sat_q;

endmodule

// File: tb/tb_bit_pattern_param_detector.sv
// Directed self-checking bench for bit_pattern_param_detector (default and CNT_W=2 instances).
module tb_bit_pattern_param_detector;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic       data = 1'b0;
    logic       cfg_we = 1'b0;
    logic [3:0] cfg_pattern = 4'b1011;
    logic [3:0] cfg_mask = 4'b1111;
    logic       cfg_overlap = 1'b1;

    logic       detect;
    logic [7:0] match_count;
    logic       count_sat;
    logic       detect_s;
    logic [1:0] match_count_s;
    logic       count_sat_s;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bit_pattern_param_detector #(
        .PAT_W(4),
        .CNT_W(8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .data       (data),
        .cfg_we     (cfg_we),
        .cfg_pattern(cfg_pattern),
        .cfg_mask   (cfg_mask),
        .cfg_overlap(cfg_overlap),
        .detect     (detect),
        .match_count(match_count),
        .count_sat  (count_sat)
    );

    bit_pattern_param_detector #(
        .PAT_W(4),
        .CNT_W(2)
    ) dut_sat (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .data       (data),
        .cfg_we     (cfg_we),
        .cfg_pattern(cfg_pattern),
        .cfg_mask   (cfg_mask),
        .cfg_overlap(cfg_overlap),
        .detect     (detect_s),
        .match_count(match_count_s),
        .count_sat  (count_sat_s)
    );

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic drive_bit(input logic d);
        in_valid = 1'b1;
        data     = d;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        data     = 1'b0;
    endtask

    task automatic do_cfg(input logic [3:0] pat, input logic [3:0] msk, input logic ovl,
                          input logic with_valid, input logic d);
        cfg_we      = 1'b1;
        cfg_pattern = pat;
        cfg_mask    = msk;
        cfg_overlap = ovl;
        in_valid    = with_valid;
        data        = d;
        @(posedge clk);
        #1;
        cfg_we   = 1'b0;
        in_valid = 1'b0;
        data     = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (detect !== 1'b0 || match_count !== 8'd0 || count_sat !== 1'b0) begin
            errors++;
            $display("FAIL reset: detect=%b count=%0d sat=%b, want 0 0 0",
                     detect, match_count, count_sat);
        end
    endtask

    task automatic test_basic();
        logic [3:0] s = 4'b1011;
        logic [3:0] e = 4'b0001;
        do_reset();
        for (int i = 3; i >= 0; i--) begin
            drive_bit(s[i]);
            checks++;
            if (detect !== e[i]) begin
                errors++;
                $display("FAIL basic_detect bit%0d: got %b want %b", 3 - i, detect, e[i]);
            end
        end
        checks++;
        if (match_count !== 8'd1) begin
            errors++;
            $display("FAIL basic_count: got %0d want 1", match_count);
        end
    endtask

    task automatic test_overlap();
        logic [6:0] s  = 7'b1011011;
        logic [6:0] eo = 7'b0001001;
        logic [6:0] en = 7'b0001000;
        do_reset();
        for (int i = 6; i >= 0; i--) begin
            drive_bit(s[i]);
            checks++;
            if (detect !== eo[i]) begin
                errors++;
                $display("FAIL overlap_detect bit%0d: got %b want %b", 6 - i, detect, eo[i]);
            end
        end
        checks++;
        if (match_count !== 8'd2) begin
            errors++;
            $display("FAIL overlap_count: got %0d want 2", match_count);
        end
        do_cfg(4'b1011, 4'b1111, 1'b0, 1'b0, 1'b0);
        for (int i = 6; i >= 0; i--) begin
            drive_bit(s[i]);
            checks++;
            if (detect !== en[i]) begin
                errors++;
                $display("FAIL nonoverlap_detect bit%0d: got %b want %b", 6 - i, detect, en[i]);
            end
        end
        checks++;
        if (match_count !== 8'd1) begin
            errors++;
            $display("FAIL nonoverlap_count: got %0d want 1", match_count);
        end
    endtask

    task automatic test_mask_gapped();
        logic [11:0] s = 12'b1111_1010_1001;
        logic [11:0] e = 12'b0001_0000_0001;
        do_reset();
        do_cfg(4'b1001, 4'b1001, 1'b0, 1'b0, 1'b0);
        for (int g = 2; g >= 0; g--) begin
            for (int i = 3; i >= 0; i--) begin
                drive_bit(s[g*4+i]);
                checks++;
                if (detect !== e[g*4+i]) begin
                    errors++;
                    $display("FAIL mask_detect group%0d bit%0d: got %b want %b",
                             2 - g, 3 - i, detect, e[g*4+i]);
                end
            end
            repeat (2) begin
                @(posedge clk);
                #1;
                checks++;
                if (detect !== 1'b0) begin
                    errors++;
                    $display("FAIL mask_idle_detect group%0d: got %b want 0", 2 - g, detect);
                end
            end
        end
        checks++;
        if (match_count !== 8'd2) begin
            errors++;
            $display("FAIL mask_count: got %0d want 2", match_count);
        end
    endtask

    task automatic test_saturation();
        logic [3:0] s = 4'b1011;
        int         exp_cnt;
        do_reset();
        for (int g = 0; g < 5; g++) begin
            for (int i = 3; i >= 0; i--) drive_bit(s[i]);
            exp_cnt = (g + 1 > 3) ? 3 : g + 1;
            checks++;
            if (detect_s !== 1'b1 || match_count_s !== 2'(exp_cnt) ||
                count_sat_s !== (g >= 2)) begin
                errors++;
                $display("FAIL sat_group%0d: detect=%b count=%0d sat=%b want 1 %0d %b",
                         g, detect_s, match_count_s, count_sat_s, exp_cnt, g >= 2);
            end
        end
        checks++;
        if (match_count !== 8'd5 || count_sat !== 1'b0) begin
            errors++;
            $display("FAIL sat_wide_count: got %0d sat=%b want 5 0", match_count, count_sat);
        end
        do_cfg(4'b1011, 4'b1111, 1'b1, 1'b0, 1'b0);
        checks++;
        if (match_count_s !== 2'd0 || count_sat_s !== 1'b0) begin
            errors++;
            $display("FAIL sat_clear: count=%0d sat=%b want 0 0", match_count_s, count_sat_s);
        end
    endtask

    task automatic test_reset_midstream();
        logic [3:0] s = 4'b1011;
        logic [3:0] e = 4'b0001;
        do_reset();
        drive_bit(1'b1);
        drive_bit(1'b0);
        drive_bit(1'b1);
        do_reset();
        drive_bit(1'b1);
        checks++;
        if (detect !== 1'b0 || match_count !== 8'd0) begin
            errors++;
            $display("FAIL rst_mid: detect=%b count=%0d want 0 0", detect, match_count);
        end
        for (int i = 3; i >= 0; i--) begin
            drive_bit(s[i]);
            checks++;
            if (detect !== e[i]) begin
                errors++;
                $display("FAIL rst_mid_after bit%0d: got %b want %b", 3 - i, detect, e[i]);
            end
        end
        checks++;
        if (match_count !== 8'd1) begin
            errors++;
            $display("FAIL rst_mid_count: got %0d want 1", match_count);
        end
    endtask

    task automatic test_cfg_priority();
        logic [6:0] s = 7'b011_1011;
        logic [6:0] e = 7'b000_0001;
        do_reset();
        drive_bit(1'b1);
        drive_bit(1'b0);
        drive_bit(1'b1);
        do_cfg(4'b1011, 4'b1111, 1'b1, 1'b1, 1'b1);
        checks++;
        if (detect !== 1'b0 || match_count !== 8'd0) begin
            errors++;
            $display("FAIL cfg_prio: detect=%b count=%0d want 0 0", detect, match_count);
        end
        for (int i = 6; i >= 0; i--) begin
            drive_bit(s[i]);
            checks++;
            if (detect !== e[i]) begin
                errors++;
                $display("FAIL cfg_prio_detect bit%0d: got %b want %b", 6 - i, detect, e[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overlap();
        test_mask_gapped();
        test_saturation();
        test_reset_midstream();
        test_cfg_priority();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
